// File: rtl/flappy_game_sequencer_pkg.sv
// flappy_game_sequencer_pkg: round states plus screen and pipe geometry shared with the renderer
package flappy_game_sequencer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2, OVER = 2'd3} state_e;
    localparam logic [10:0] H_MIN        = 11'd144;
    localparam logic [10:0] GROUND_Y     = 11'd514;
    localparam logic [10:0] PIPE_W       = 11'd40;
    localparam logic [10:0] PIPE_SPACING = 11'd400;
    localparam logic [10:0] PIPE_X0      = 11'd784;
    localparam logic [10:0] PIPE_SPEED   = 11'd2;
    localparam logic [10:0] GAP_H        = 11'd120;
    localparam logic [9:0]  GAP_BASE     = 10'd75;
    localparam logic [9:0]  GAP_INIT     = GAP_BASE + 10'd60;
    localparam logic [10:0] BIRD_HALF    = 11'd5;
    localparam logic [5:0]  DEAD_TICKS   = 6'd60;
endpackage

// File: rtl/flappy_game_sequencer_pipe_lane.sv
// flappy_game_sequencer_pipe_lane: one scrolling pipe with gap, wrap, passed flag and bird hit/pass detect
module flappy_game_sequencer_pipe_lane
    import flappy_game_sequencer_pkg::*;
#(
    parameter logic [10:0] X_INIT = PIPE_X0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_i,
    input  logic        move_i,
    input  logic [7:0]  lfsr_i,
    input  logic [9:0]  bird_x_i,
    input  logic [9:0]  bird_y_i,
    output logic [10:0] x_o,
    output logic [9:0]  gap_o,
    output logic        hit_o,
    output logic        pass_o
);
    logic [10:0] x_q, x_d, bx, by, gy;
    logic [9:0]  gap_q, gap_d;
    logic        passed_q, passed_d, wrap;

    always_comb begin
        bx = {1'b0, bird_x_i};
        by = {1'b0, bird_y_i};
        gy = {1'b0, gap_q};
        wrap = x_q < H_MIN + PIPE_SPEED;
        // bird half-size is moved onto the pipe side of each compare so nothing underflows
        hit_o = (bx + BIRD_HALF >= x_q) && (bx <= x_q + PIPE_W - 11'd1 + BIRD_HALF)
             && ((by < gy + BIRD_HALF) || (by > gy + GAP_H - 11'd1 - BIRD_HALF));
        pass_o = !passed_q && (x_q + PIPE_W - 11'd1 + BIRD_HALF < bx);
        x_d = init_i ? X_INIT : !move_i ? x_q
            : wrap ? x_q - PIPE_SPEED + (PIPE_SPACING << 1) : x_q - PIPE_SPEED;
        gap_d = init_i ? GAP_INIT : (move_i && wrap) ? GAP_BASE + {2'b0, lfsr_i} : gap_q;
        passed_d = init_i ? 1'b0 : !move_i ? passed_q : wrap ? 1'b0 : passed_q | pass_o;
        x_o = x_q;
        gap_o = gap_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= X_INIT;
            gap_q <= GAP_INIT;
            passed_q <= 1'b0;
        end else begin
            x_q <= x_d;
            gap_q <= gap_d;
            passed_q <= passed_d;
        end
    end
endmodule

// File: rtl/flappy_game_sequencer.sv
// flappy_game_sequencer: round FSM, gap LFSR, collision and score keeping around two pipe lanes
module flappy_game_sequencer
    import flappy_game_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flap,
    input  logic [9:0]  bird_x,
    input  logic [9:0]  bird_y,
    output logic [10:0] pipe0_x,
    output logic [9:0]  pipe0_gap,
    output logic [10:0] pipe1_x,
    output logic [9:0]  pipe1_gap,
    output logic [7:0]  score,
    output logic [7:0]  hi_score,
    output logic [1:0]  state,
    output logic        bird_hold,
    output logic        bird_reinit,
    output logic        game_over
);
    state_e      state_q;
    logic [7:0]  lfsr_q, score_q, hi_q;
    logic [5:0]  cnt_q;
    logic        flap_q, hold_q, reinit_q, over_q;
    logic        flap_rise, crash, init, move, hit0, hit1, pass0, pass1;
    logic [8:0]  sum;

    always_comb begin
        flap_rise = flap & ~flap_q;
        crash = ({1'b0, bird_y} >= GROUND_Y) || hit0 || hit1;
        init = (state_q == OVER) && flap_rise;
        move = (state_q == RUN) && !crash;
        sum = {1'b0, score_q} + {8'b0, pass0} + {8'b0, pass1};
    end

    flappy_game_sequencer_pipe_lane #(.X_INIT(PIPE_X0)) u_lane0 (
        .clk(clk), .rst(rst), .init_i(init), .move_i(move), .lfsr_i(lfsr_q),
        .bird_x_i(bird_x), .bird_y_i(bird_y), .x_o(pipe0_x), .gap_o(pipe0_gap),
        .hit_o(hit0), .pass_o(pass0)
    );

    flappy_game_sequencer_pipe_lane #(.X_INIT(PIPE_X0 + PIPE_SPACING)) u_lane1 (
        .clk(clk), .rst(rst), .init_i(init), .move_i(move), .lfsr_i(lfsr_q),
        .bird_x_i(bird_x), .bird_y_i(bird_y), .x_o(pipe1_x), .gap_o(pipe1_gap),
        .hit_o(hit1), .pass_o(pass1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q <= 8'hA5;
            score_q <= 8'd0;
            hi_q <= 8'd0;
            cnt_q <= 6'd0;
            flap_q <= 1'b0;
            hold_q <= 1'b1;
            reinit_q <= 1'b0;
            over_q <= 1'b0;
        end else begin
            flap_q <= flap;
            // free-running so the moment the player starts picks the gap sequence
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            reinit_q <= init;
            case (state_q)
                IDLE: if (flap_rise) begin
                    state_q <= RUN;
                    hold_q <= 1'b0;
                end
                RUN: if (crash) begin
                    state_q <= DEAD;
                    hold_q <= 1'b1;
                    over_q <= 1'b1;
                    cnt_q <= 6'd0;
                    hi_q <= (score_q > hi_q) ? score_q : hi_q;
                end else begin
                    score_q <= sum[8] ? 8'hFF : sum[7:0];
                end
                DEAD: if (cnt_q == DEAD_TICKS - 6'd1) state_q <= OVER;
                      else cnt_q <= cnt_q + 6'd1;
                OVER: if (flap_rise) begin
                    state_q <= IDLE;
                    score_q <= 8'd0;
                    over_q <= 1'b0;
                end
            endcase
        end
    end

    assign score = score_q;
    assign hi_score = hi_q;
    assign state = state_q;
    assign bird_hold = hold_q;
    assign bird_reinit = reinit_q;
    assign game_over = over_q;
endmodule

// File: doc/flappy_game_sequencer.md
Name: flappy_game_sequencer

Overview:
- Game-level controller for the Flappy Bird datapath. It sequences a round through IDLE, RUN, DEAD and OVER.
- Scrolls two pipes and randomises their gaps with an LFSR, detects bird/pipe/ground collisions, and keeps the current and high scores.
- Sits between the bird-position block and the renderer. It consumes the bird centre and drives pipe geometry, score and bird hold/re-init controls.
- Runs on the same slow game-tick clock as the bird block.

Parameters:
- H_MIN, 144, first visible hCount column
- GROUND_Y, 514, last visible vCount row; a bird centre at or beyond this row is a crash
- PIPE_W, 40, pipe width in pixels
- PIPE_SPACING, 400, horizontal distance between pipe0 and pipe1
- PIPE_X0, 784, initial pipe0 left edge; pipe1 starts at PIPE_X0+PIPE_SPACING
- PIPE_SPEED, 2, pixels moved per tick while RUN
- GAP_H, 120, vertical gap height
- GAP_BASE, 75, minimum gap top
- BIRD_HALF, 5, bird half-size
- DEAD_TICKS, 60, ticks spent in DEAD before OVER

Ports:
- clk  in  1  game tick clock
- rst  in  1  reset; asynchronous, active-high
- flap  in  1  up button, level
- bird_x  in  10  bird centre column
- bird_y  in  10  bird centre row
- pipe0_x  out  11  pipe0 left edge (may be off-screen)
- pipe0_gap  out  10  pipe0 gap top row
- pipe1_x  out  11  pipe1 left edge
- pipe1_gap  out  10  pipe1 gap top row
- score  out  8  current score, saturating
- hi_score  out  8  best score since rst
- state  out  2  0 IDLE, 1 RUN, 2 DEAD, 3 OVER
- bird_hold  out  1  bird block must freeze when high
- bird_reinit  out  1  one-tick pulse; bird block re-centres
- game_over  out  1  high in DEAD and OVER

Behaviour:
- Reset values:
  - state IDLE; score 0; hi_score 0
  - pipe0_x PIPE_X0; pipe1_x PIPE_X0+PIPE_SPACING; both gaps GAP_BASE+60
  - bird_hold 1; bird_reinit 0; game_over 0; dead counter 0
  - LFSR 8'hA5; passed flags 0; flap_q 0
- Flap edge: flap_rise = flap & ~flap_q, with flap_q registered every tick.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every tick in every state, so the start time randomises the gaps. The register never holds 0.
- IDLE:
  - Pipes held at their initial values; bird_hold=1.
  - flap_rise -> RUN, with bird_hold=0 from the next tick.
- RUN, pipe move (per pipe, each tick):
  - If x < H_MIN+PIPE_SPEED: x <= x - PIPE_SPEED + 2*PIPE_SPACING, gap <= GAP_BASE + lfsr, passed flag cleared.
  - Otherwise: x <= x - PIPE_SPEED.
  - All arithmetic is 11-bit unsigned and never underflows. Maximum gap bottom is 75+255+119 = 449 < GROUND_Y.
- RUN, collision (combinational on current registers):
  - Ground: bird_y >= GROUND_Y.
  - Pipe p, horizontal overlap: bird_x+BIRD_HALF >= x_p and bird_x-BIRD_HALF <= x_p+PIPE_W-1.
  - Pipe p, vertical hit: bird_y-BIRD_HALF < gap_p or bird_y+BIRD_HALF > gap_p+GAP_H-1.
  - A pipe collision needs both overlap and vertical hit.
  - Any collision -> DEAD next tick; pipes do not move on that tick.
- RUN, score: when x_p+PIPE_W-1 < bird_x-BIRD_HALF and the pipe's passed flag is 0, set the flag and increment score.
  - Score saturates at 255.
  - Collision and score on the same tick: collision wins, no increment.
  - Both pipes passing on the same tick: +2, still saturating.
- DEAD:
  - Pipes frozen; bird_hold=1; game_over=1.
  - Dead counter counts DEAD_TICKS ticks, then -> OVER.
  - On DEAD entry, hi_score <= max(hi_score, score).
  - flap is ignored.
- OVER:
  - Frozen; game_over=1.
  - flap_rise -> IDLE: score cleared, pipes, gaps and passed flags re-initialised.
  - bird_reinit pulses high for exactly the IDLE entry tick.
- Asserting rst at any time restores all reset values, including hi_score. Its effect is immediate (asynchronous).

Decomposition:
- Shared package holds:
  - state encodings
  - screen constants H_MIN and GROUND_Y, shared with the renderer
  - PIPE_W and GAP_H, shared with the renderer for drawing
- One natural sub-module: pipe_lane, instantiated twice. It holds one pipe's x/gap registers, wrap logic, passed flag and collision/pass detect.
- LFSR and FSM stay in the top.

Test Plan:
- Reset, then hold flap low for 50 ticks -> state stays 0; pipe0_x 784, pipe1_x 1184; bird_hold 1; score 0.
- flap rising edge in IDLE -> state 1 the next tick; pipe0_x decrements by 2 per tick (784, 782, 780, ...).
- Drive pipe0_x down to 145 in RUN -> next value is 145-2+800 = 943; gap equals 75 + the LFSR value on that tick; passed flag clear.
- Bird at (450, gap+60) while pipe0 passes -> no collision; score goes 0 to 1 on the tick x+39 < 445; no double count before wrap.
- bird_y = 514 in RUN -> DEAD; game_over 1; pipes frozen; after 60 ticks state 3; hi_score = score.
- In OVER with score 3 and hi_score 5, flap edge -> IDLE with bird_reinit high for 1 tick, score 0, hi_score 5; rst asserted mid-RUN -> all outputs at reset values immediately.
